// File: rtl/cnn_pool_engine.sv
// 2x2 stride-2 signed max-pooling engine streaming CHANNELS stacked IN_DIM x IN_DIM maps.
// Define CNN_POOL_RELU_EN to clamp negative pooled results to zero before writing.
module cnn_pool_engine #(
  parameter int DATA_W   = 8,
  parameter int IN_DIM   = 28,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 12
) (
  input  logic              CNN_Pool_CLOCK_50,
  input  logic              CNN_Pool_RESET_InLow,
  input  logic              CNN_Pool_Enable_InHigh,
  output logic              CNN_Pool_Done_Out,
  output logic [ADDR_W-1:0] CNN_Pool_RdAddr_Out,
  input  logic [DATA_W-1:0] CNN_Pool_RdData_In,
  output logic [ADDR_W-1:0] CNN_Pool_WrAddr_Out,
  output logic [DATA_W-1:0] CNN_Pool_WrData_Out,
  output logic              CNN_Pool_WrEn_Out
);

  localparam int OD = IN_DIM / 2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAST, S_WR, S_DONE} state_t;

  state_t                    state_q;
  logic [1:0]                k_q;
  logic [ADDR_W-1:0]         row_q, col_q, ch_q;
  logic [ADDR_W-1:0]         row_d, col_d, ch_d;
  logic signed [DATA_W-1:0]  max_q, wr_data_q;
  logic [ADDR_W-1:0]         rd_addr_q, wr_addr_q;
  logic                      wr_en_q, done_q;

  logic signed [DATA_W-1:0]  rd_data_s, max_fin_s, result_s;
  logic                      greater_s, col_wrap_s, row_wrap_s, last_s;

  // Window tap k walks (0,0),(0,1),(1,0),(1,1): dy = k[1], dx = k[0].
  function automatic logic [ADDR_W-1:0] rd_addr_f(input logic [ADDR_W-1:0] ch,
                                                  input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col,
                                                  input logic [1:0]        k);
    rd_addr_f = ch * ADDR_W'(IN_DIM * IN_DIM)
              + {row[ADDR_W-2:0], k[1]} * ADDR_W'(IN_DIM)
              + {col[ADDR_W-2:0], k[0]};
  endfunction

  function automatic logic [ADDR_W-1:0] wr_addr_f(input logic [ADDR_W-1:0] ch,
                                                  input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
    wr_addr_f = ch * ADDR_W'(OD * OD) + row * ADDR_W'(OD) + col;
  endfunction

  assign rd_data_s  = $signed(CNN_Pool_RdData_In);
  assign greater_s  = rd_data_s > max_q;
  assign col_wrap_s = (col_q == ADDR_W'(OD - 1));
  assign row_wrap_s = (row_q == ADDR_W'(OD - 1));
  assign last_s     = col_wrap_s && row_wrap_s && (ch_q == ADDR_W'(CHANNELS - 1));
  assign col_d      = col_wrap_s ? '0 : col_q + ADDR_W'(1);
  assign row_d      = col_wrap_s ? (row_wrap_s ? '0 : row_q + ADDR_W'(1)) : row_q;
  assign ch_d       = (col_wrap_s && row_wrap_s) ? ch_q + ADDR_W'(1) : ch_q;

  // Final window maximum, optionally rectified.
  always_comb begin
    max_fin_s = greater_s ? rd_data_s : max_q;
`ifdef CNN_POOL_RELU_EN
    result_s  = max_fin_s[DATA_W-1] ? '0 : max_fin_s;
`else
    result_s  = max_fin_s;
`endif
  end

  // Sequencer: reads each 2x2 window, tracks the running max, writes one element.
  always_ff @(posedge CNN_Pool_CLOCK_50 or negedge CNN_Pool_RESET_InLow) begin
    if (!CNN_Pool_RESET_InLow) begin
      state_q   <= S_IDLE;
      k_q       <= 2'd0;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      max_q     <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (CNN_Pool_Enable_InHigh && !done_q) begin
            state_q   <= S_RD;
            k_q       <= 2'd0;
            row_q     <= '0;
            col_q     <= '0;
            ch_q      <= '0;
            rd_addr_q <= '0;
          end
        end
        S_RD: begin
          if (!CNN_Pool_Enable_InHigh) begin
            state_q <= S_IDLE;
          end else begin
            // Data for tap k-1 arrives while tap k is addressed.
            if (k_q == 2'd1) begin
              max_q <= rd_data_s;
            end else if (k_q != 2'd0 && greater_s) begin
              max_q <= rd_data_s;
            end
            if (k_q == 2'd3) begin
              state_q <= S_LAST;
            end else begin
              k_q       <= k_q + 2'd1;
              rd_addr_q <= rd_addr_f(ch_q, row_q, col_q, k_q + 2'd1);
            end
          end
        end
        S_LAST: begin
          if (!CNN_Pool_Enable_InHigh) begin
            state_q <= S_IDLE;
          end else begin
            wr_data_q <= result_s;
            wr_addr_q <= wr_addr_f(ch_q, row_q, col_q);
            wr_en_q   <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          wr_en_q <= 1'b0;
          if (!CNN_Pool_Enable_InHigh) begin
            state_q <= S_IDLE;
          end else if (last_s) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            k_q       <= 2'd0;
            rd_addr_q <= rd_addr_f(ch_d, row_d, col_d, 2'd0);
            state_q   <= S_RD;
          end
        end
        S_DONE: begin
          wr_en_q <= 1'b0;
          if (!CNN_Pool_Enable_InHigh) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CNN_Pool_Done_Out   = done_q;
  assign CNN_Pool_RdAddr_Out = rd_addr_q;
  assign CNN_Pool_WrAddr_Out = wr_addr_q;
  assign CNN_Pool_WrData_Out = wr_data_q;
  assign CNN_Pool_WrEn_Out   = wr_en_q;

endmodule

// File: tb/tb_cnn_pool_engine.sv
// Directed bench for cnn_pool_engine with IN_DIM=4, CHANNELS=2 and a 1-cycle-latency input memory.
module tb_cnn_pool_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data = '0, wr_data;
  logic              wr_en;

  logic [7:0] mem [32];

  int n_checks = 0;
  int n_pass   = 0;

  // Results captured by run_collect.
  int         nw;
  int         done_cyc;
  logic [7:0] wa [16];
  logic [7:0] wd [16];
  int         wc [16];
  logic [7:0] exp_d [8];

  cnn_pool_engine #(.DATA_W(DATA_W), .IN_DIM(4), .CHANNELS(2), .ADDR_W(ADDR_W)) dut (
    .CNN_Pool_CLOCK_50     (clk),
    .CNN_Pool_RESET_InLow  (rst_n),
    .CNN_Pool_Enable_InHigh(en),
    .CNN_Pool_Done_Out     (done),
    .CNN_Pool_RdAddr_Out   (rd_addr),
    .CNN_Pool_RdData_In    (rd_data),
    .CNN_Pool_WrAddr_Out   (wr_addr),
    .CNN_Pool_WrData_Out   (wr_data),
    .CNN_Pool_WrEn_Out     (wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Raise enable at a negedge and log writes until Done or the budget runs out.
  task automatic run_collect(input int budget);
    nw = 0;
    done_cyc = 0;
    en = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (wr_en && nw < 16) begin
        wa[nw] = {2'b00, wr_addr};
        wd[nw] = wr_data;
        wc[nw] = c;
        nw++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag);
    check({tag, "_nwrites"}, nw, 8);
    check({tag, "_done_cycle"}, done_cyc, 49);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa[i], i);
      check($sformatf("%s_data%0d", tag, i), wd[i], exp_d[i]);
      check($sformatf("%s_cyc%0d", tag, i), wc[i], 6 * (i + 1));
    end
  endtask

  initial begin
    int n_we, n_dn;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[16] = 8'hFD; mem[17] = 8'hFF; mem[18] = 8'd4;  mem[19] = 8'd4;
    mem[20] = 8'hF8; mem[21] = 8'hFE; mem[22] = 8'd6;  mem[23] = 8'd5;
    mem[24] = 8'd1;  mem[25] = 8'd9;  mem[26] = 8'h81; mem[27] = 8'h80;
    mem[28] = 8'd2;  mem[29] = 8'd3;  mem[30] = 8'h80; mem[31] = 8'h80;
    exp_d[0] = 8'd5; exp_d[1] = 8'd7; exp_d[2] = 8'd13; exp_d[3] = 8'd15;
    exp_d[5] = 8'd6; exp_d[6] = 8'd9;
`ifdef CNN_POOL_RELU_EN
    exp_d[4] = 8'h00; exp_d[7] = 8'h00;
`else
    exp_d[4] = 8'hFF; exp_d[7] = 8'h81;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_wren", wr_en, 0);
    check("rst_rdaddr", rd_addr, 0);
    check("rst_wraddr", wr_addr, 0);
    check("rst_wrdata", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full run, then Done held with Enable high and no restart
    run_collect(80);
    check_run("run1");
    n_we = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_en) n_we++;
    end
    check("hold_done", done, 1);
    check("hold_no_wren", n_we, 0);
    en = 1'b0;
    @(negedge clk);
    check("drop_done_clear", done, 0);

    // Second run repeats the same writes
    run_collect(80);
    check_run("run2");
    en = 1'b0;
    @(negedge clk);

    // Abort during RD of element 2 (cycle 14 addresses tap k=1 at 9)
    n_we = 0;
    en = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (wr_en) n_we++;
    end
    check("abort_rdaddr_k1", rd_addr, 9);
    en = 1'b0;
    check("abort_prior_writes", n_we, 2);
    n_we = 0;
    n_dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wr_en) n_we++;
      if (done) n_dn++;
    end
    check("abort_no_wren", n_we, 0);
    check("abort_no_done", n_dn, 0);
    check("abort_rdaddr_held", rd_addr, 9);

    // Restart after abort begins from element 0
    run_collect(80);
    check_run("run3");
    en = 1'b0;
    @(negedge clk);

    // Reset during the first WR
    en = 1'b1;
    for (int c = 1; c <= 6; c++) @(negedge clk);
    check("wr_before_rst", wr_en, 1);
    check("wrdata_before_rst", wr_data, 5);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("rst_mid_wren", wr_en, 0);
    check("rst_mid_wrdata", wr_data, 0);
    check("rst_mid_wraddr", wr_addr, 0);
    check("rst_mid_rdaddr", rd_addr, 0);
    check("rst_mid_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_collect(80);
    check_run("run4");
    en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
